// File: rtl/digit_scan_ctrl.sv
// Seven-segment scan controller: DIV-cycle dwell per digit, frame-synchronous display shadow register.
// Optional macro DIGIT_SCAN_BLANK_EN adds a registered blanking pulse at the start of each dwell.
module digit_scan_ctrl #(
  parameter int unsigned DIV    = 50000,
  parameter int unsigned DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  output logic [2:0]  sel,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        tick,
  output logic        frame_done,
  output logic        blank
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [2:0]    SMAX = 3'(DIGITS - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          tick_q, tick_d;
  logic          fd_q, fd_d;
  logic [39:0]   hold_q, hold_d;
  logic [39:0]   disp_q, disp_d;
  logic          wrap, frame_wrap;
  logic [39:0]   next_disp;

  // sel beyond DIGITS-1 is treated like the last digit so a forced value recovers at the next wrap
  assign wrap       = en && (pcnt_q == PMAX);
  assign frame_wrap = wrap && (sel_q >= SMAX);
  assign next_disp  = load ? {data, dp_in} : hold_q;

  always_comb begin
    pcnt_d = pcnt_q;
    sel_d  = sel_q;
    hold_d = hold_q;
    disp_d = disp_q;
    tick_d = wrap;
    fd_d   = frame_wrap;
    if (en) begin
      pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
    end
    if (wrap) begin
      sel_d = frame_wrap ? 3'd0 : sel_q + 3'd1;
    end
    if (load) begin
      hold_d = {data, dp_in};
    end
    // A stopped display tracks new values immediately instead of waiting for a frame
    if (frame_wrap || !en) begin
      disp_d = next_disp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      sel_q  <= '0;
      tick_q <= 1'b0;
      fd_q   <= 1'b0;
      hold_q <= '0;
      disp_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
      fd_q   <= fd_d;
      hold_q <= hold_d;
      disp_q <= disp_d;
    end
  end

  assign sel        = sel_q;
  assign tick       = tick_q;
  assign frame_done = fd_q;
  assign digit      = disp_q[8 + {sel_q, 2'b00} +: 4];
  assign dp         = disp_q[sel_q];

`ifdef DIGIT_SCAN_BLANK_EN
  localparam logic [PW:0] BLANK_N = (DIV / 8 > 1) ? (PW+1)'(DIV / 8) : (PW+1)'(1);

  logic blank_q, blank_d;

  // Compare against the next count so blank lines up with the pcnt value it describes
  always_comb begin
    blank_d = blank_q;
    if (en) begin
      blank_d = ({1'b0, pcnt_d} < BLANK_N);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with DIV=4, DIGITS=8; outputs sampled 1 time unit after each rising edge.
module tb_digit_scan_ctrl;

  localparam int unsigned DIV    = 4;
  localparam int unsigned DIGITS = 8;
`ifdef DIGIT_SCAN_BLANK_EN
  localparam logic BLK = 1'b1;
`else
  localparam logic BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] data;
  logic [7:0]  dp_in;
  logic [2:0]  sel;
  logic [3:0]  digit;
  logic        dp;
  logic        tick;
  logic        frame_done;
  logic        blank;

  int npass  = 0;
  int ntotal = 0;

  digit_scan_ctrl #(.DIV(DIV), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_in(dp_in),
    .sel(sel), .digit(digit), .dp(dp), .tick(tick), .frame_done(frame_done),
    .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ntotal++;
    assert (obs === want) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s, input logic [3:0] d,
                         input logic p, input logic t, input logic f);
    chk({tag, ".sel"},   32'(sel),        32'(s));
    chk({tag, ".digit"}, 32'(digit),      32'(d));
    chk({tag, ".dp"},    32'(dp),         32'(p));
    chk({tag, ".tick"},  32'(tick),       32'(t));
    chk({tag, ".fdone"}, 32'(frame_done), 32'(f));
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    data  = '0;
    dp_in = '0;
    cyc(2);
    chk_all("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.blank", 32'(blank), 32'd0);

    // Free-running scan over one full frame
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(3);
      chk("scan.notick", 32'(tick), 32'd0);
      chk("scan.blank_off", 32'(blank), 32'd0);
      cyc(1);
      chk_all("scan.step", 3'(k % 8), 4'd0, 1'b0, 1'b1, (k % 8) == 0);
      chk("scan.blank_on", 32'(blank), 32'(BLK));
    end

    // Load mid-frame at sel=3: not visible until the 7->0 wrap
    cyc(12);
    chk("ld.at_sel3", 32'(sel), 32'd3);
    load  = 1'b1;
    data  = 32'h8765_4321;
    dp_in = 8'h01;
    cyc(1);
    load = 1'b0;
    chk("ld.pending", 32'(digit), 32'd0);
    cyc(18);
    chk_all("ld.last_old", 3'd7, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_all("ld.wrap", 3'd0, 4'd1, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) begin
      cyc(4);
      chk_all("ld.show", 3'(k), 4'(k + 1), 1'b0, 1'b1, 1'b0);
    end

    // Load coincident with the wrap bypasses the hold register
    cyc(3);
    load  = 1'b1;
    data  = 32'hFFFF_FFFF;
    dp_in = 8'h00;
    cyc(1);
    load = 1'b0;
    chk_all("byp.wrap", 3'd0, 4'hF, 1'b0, 1'b1, 1'b1);
    cyc(5);
    load  = 1'b1;
    data  = 32'h2222_2222;
    dp_in = 8'hFF;
    cyc(1);
    load = 1'b0;
    chk_all("byp.second_wait", 3'd1, 4'hF, 1'b0, 1'b0, 1'b0);
    cyc(25);
    chk_all("byp.before", 3'd7, 4'hF, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_all("byp.next", 3'd0, 4'h2, 1'b1, 1'b1, 1'b1);

    // Stop at sel=5, pcnt=2; a load shows immediately; resume after 2 cycles
    cyc(22);
    chk("stop.sel", 32'(sel), 32'd5);
    en = 1'b0;
    cyc(3);
    chk_all("stop.frozen", 3'd5, 4'h2, 1'b1, 1'b0, 1'b0);
    load  = 1'b1;
    data  = 32'h1111_1111;
    dp_in = 8'h20;
    cyc(1);
    load = 1'b0;
    chk_all("stop.load", 3'd5, 4'h1, 1'b1, 1'b0, 1'b0);
    cyc(6);
    chk_all("stop.held", 3'd5, 4'h1, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc(1);
    chk_all("resume.one", 3'd5, 4'h1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("resume.tick", 3'd6, 4'h1, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-dwell clears everything before the next edge
    cyc(2);
    #2;
    rst = 1'b1;
    #1;
    chk_all("arst", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("arst.blank", 32'(blank), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    chk_all("arst.wait", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_all("arst.first", 3'd1, 4'd0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
